// File: rtl/ysyx_23060136_wbu_csr_writer_pkg.sv
// Shared definitions for the WBU CSR write sequencer: CSR indices, op codes,
// mstatus field positions and the sequencer state encoding.
package ysyx_23060136_wbu_csr_writer_pkg;

  localparam int CSR_MSTATUS   = 0;
  localparam int CSR_MTVEC     = 1;
  localparam int CSR_MEPC      = 2;
  localparam int CSR_MCAUSE    = 3;
  localparam int CSR_MVENDORID = 4;
  localparam int CSR_MARCHID   = 5;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_ECALL = 2'd2,
    OP_MRET  = 2'd3
  } op_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int MCAUSE_ECALL_M = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_E_EPC,
    S_E_CAUSE,
    S_E_STAT,
    S_M_STAT,
    S_REDIR
  } state_e;

endpackage

// File: rtl/ysyx_23060136_wbu_csr_writer_mstatus_xform.sv
// Combinational mstatus update for trap entry (ECALL) and trap return (MRET).
// Only MIE, MPIE and MPP change; every other bit passes through.
module ysyx_23060136_wbu_mstatus_xform
  import ysyx_23060136_wbu_csr_writer_pkg::*;
#(
  parameter int BITS_W = 32
) (
  input  logic [BITS_W-1:0] snap,
  input  logic              is_mret,
  output logic [BITS_W-1:0] mstatus_new
);

  always_comb begin
    mstatus_new = snap;
    mstatus_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    if (is_mret) begin
      mstatus_new[MSTATUS_MIE]  = snap[MSTATUS_MPIE];
      mstatus_new[MSTATUS_MPIE] = 1'b1;
    end else begin
      mstatus_new[MSTATUS_MPIE] = snap[MSTATUS_MIE];
      mstatus_new[MSTATUS_MIE]  = 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_23060136_wbu_csr_writer.sv
// Serializes committed CSR writes, ECALL and MRET onto the CSR file's single
// write port, followed by a one-cycle PC redirect for traps and returns.
module ysyx_23060136_wbu_csr_writer
  import ysyx_23060136_wbu_csr_writer_pkg::*;
#(
  parameter int BITS_W = 32,
  parameter int CSR_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [CSR_W-1:0]  in_csr_rd,
  input  logic [BITS_W-1:0] in_wdata,
  input  logic [BITS_W-1:0] in_pc,
  input  logic [BITS_W-1:0] mstatus_cur,
  input  logic [BITS_W-1:0] mtvec_cur,
  input  logic [BITS_W-1:0] mepc_cur,
  output logic              CSRWr,
  output logic [CSR_W-1:0]  WBU_csr_rd,
  output logic [BITS_W-1:0] csr_busW,
  output logic              redirect_valid,
  output logic [BITS_W-1:0] redirect_pc,
  output logic              illegal_wr
);

  state_e            state;
  logic [BITS_W-1:0] mstatus_snap;
  logic [BITS_W-1:0] mtvec_snap;
  logic [BITS_W-1:0] mepc_snap;
  logic [BITS_W-1:0] xform_in;
  logic [BITS_W-1:0] xform_out;
  logic              xform_mret;
  op_e               op;
  logic              wr_legal;
  logic              wr_read_only;

  assign in_ready = (state == S_IDLE);
  assign op       = op_e'(in_op);

  // Outputs are registered on the edge that enters a state, so MRET's mstatus
  // write is formed from the live value at accept; ECALL's uses the snapshot.
  assign xform_mret = (state == S_IDLE);
  assign xform_in   = (state == S_IDLE) ? mstatus_cur : mstatus_snap;

  assign wr_legal     = (in_csr_rd <= CSR_W'(CSR_MCAUSE));
  assign wr_read_only = (in_csr_rd == CSR_W'(CSR_MVENDORID)) ||
                        (in_csr_rd == CSR_W'(CSR_MARCHID));

  ysyx_23060136_wbu_mstatus_xform #(
    .BITS_W (BITS_W)
  ) u_mstatus_xform (
    .snap        (xform_in),
    .is_mret     (xform_mret),
    .mstatus_new (xform_out)
  );

  // NOTE: all state and outputs use non-blocking assignments so every branch
  // reads the pre-edge values; pulse outputs default low and are re-raised only
  // by the branch that needs them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      CSRWr          <= 1'b0;
      WBU_csr_rd     <= '0;
      csr_busW       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      illegal_wr     <= 1'b0;
      mstatus_snap   <= '0;
      mtvec_snap     <= '0;
      mepc_snap      <= '0;
    end else begin
      CSRWr          <= 1'b0;
      redirect_valid <= 1'b0;
      illegal_wr     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mstatus_snap <= mstatus_cur;
            mtvec_snap   <= mtvec_cur;
            mepc_snap    <= mepc_cur;
            case (op)
              OP_ECALL: begin
                state      <= S_E_EPC;
                CSRWr      <= 1'b1;
                WBU_csr_rd <= CSR_W'(CSR_MEPC);
                csr_busW   <= in_pc;
              end
              OP_MRET: begin
                state      <= S_M_STAT;
                CSRWr      <= 1'b1;
                WBU_csr_rd <= CSR_W'(CSR_MSTATUS);
                csr_busW   <= xform_out;
              end
              OP_WRITE: begin
                state <= S_WR;
                if (wr_legal) begin
                  CSRWr      <= 1'b1;
                  WBU_csr_rd <= in_csr_rd;
                  csr_busW   <= in_wdata;
                end else begin
                  illegal_wr <= wr_read_only;
                end
              end
              default: state <= S_WR;
            endcase
          end
        end
        S_E_EPC: begin
          state      <= S_E_CAUSE;
          CSRWr      <= 1'b1;
          WBU_csr_rd <= CSR_W'(CSR_MCAUSE);
          csr_busW   <= BITS_W'(MCAUSE_ECALL_M);
        end
        S_E_CAUSE: begin
          state      <= S_E_STAT;
          CSRWr      <= 1'b1;
          WBU_csr_rd <= CSR_W'(CSR_MSTATUS);
          csr_busW   <= xform_out;
        end
        S_E_STAT: begin
          state          <= S_REDIR;
          redirect_valid <= 1'b1;
          redirect_pc    <= {mtvec_snap[BITS_W-1:2], 2'b00};
        end
        S_M_STAT: begin
          state          <= S_REDIR;
          redirect_valid <= 1'b1;
          redirect_pc    <= mepc_snap;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060136_wbu_csr_writer.sv
// Self-checking bench: a per-edge schedule of expected port activity is built
// from the op rules at accept time and compared on every falling edge.
module tb_ysyx_23060136_wbu_csr_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd0;
  logic [2:0]  in_csr_rd = 3'd0;
  logic [31:0] in_wdata = 32'h0;
  logic [31:0] in_pc = 32'h0;
  logic [31:0] mstatus_cur = 32'h0;
  logic [31:0] mtvec_cur = 32'h0;
  logic [31:0] mepc_cur = 32'h0;
  logic        CSRWr;
  logic [2:0]  WBU_csr_rd;
  logic [31:0] csr_busW;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        illegal_wr;

  ysyx_23060136_wbu_csr_writer #(.BITS_W(32), .CSR_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_csr_rd      (in_csr_rd),
    .in_wdata       (in_wdata),
    .in_pc          (in_pc),
    .mstatus_cur    (mstatus_cur),
    .mtvec_cur      (mtvec_cur),
    .mepc_cur       (mepc_cur),
    .CSRWr          (CSRWr),
    .WBU_csr_rd     (WBU_csr_rd),
    .csr_busW       (csr_busW),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .illegal_wr     (illegal_wr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        wr;
    logic [2:0]  rd;
    logic [31:0] data;
    logic        rv;
    logic [31:0] rpc;
    logic        ill;
  } exp_t;

  localparam exp_t QUIET = '{wr: 1'b0, rd: 3'd0, data: 32'h0, rv: 1'b0, rpc: 32'h0, ill: 1'b0};

  exp_t sched[int];
  int   edge_n = 0;
  int   busy_until = -10;   // DUT is busy after every edge k <= busy_until

  function automatic exp_t wr_ev(input int rd, input logic [31:0] d);
    exp_t x = QUIET;
    x.wr = 1'b1; x.rd = 3'(rd); x.data = d;
    return x;
  endfunction

  function automatic logic [31:0] trap_status(input logic [31:0] m);
    return (m & ~32'h0000_1888) | 32'h0000_1800 | (((m >> 3) & 32'h1) << 7);
  endfunction

  function automatic logic [31:0] ret_status(input logic [31:0] m);
    return (m & ~32'h0000_1888) | 32'h0000_1880 | (((m >> 7) & 32'h1) << 3);
  endfunction

  always @(posedge clk) begin
    exp_t x;
    int   e;
    edge_n++;
    e = edge_n;
    if (!rst) begin
      sched.delete();
      busy_until = -10;
    end else if (in_valid && busy_until < e - 1) begin
      case (in_op)
        2'd1: begin
          busy_until = e;
          if (in_csr_rd <= 3) sched[e] = wr_ev(int'(in_csr_rd), in_wdata);
          else if (in_csr_rd == 4 || in_csr_rd == 5) begin
            x = QUIET; x.ill = 1'b1; sched[e] = x;
          end
        end
        2'd2: begin
          busy_until = e + 3;
          sched[e]     = wr_ev(2, in_pc);
          sched[e + 1] = wr_ev(3, 32'd11);
          sched[e + 2] = wr_ev(0, trap_status(mstatus_cur));
          x = QUIET; x.rv = 1'b1; x.rpc = mtvec_cur & ~32'h3; sched[e + 3] = x;
        end
        2'd3: begin
          busy_until = e + 1;
          sched[e] = wr_ev(0, ret_status(mstatus_cur));
          x = QUIET; x.rv = 1'b1; x.rpc = mepc_cur; sched[e + 1] = x;
        end
        default: busy_until = e;
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      x = sched.exists(edge_n) ? sched[edge_n] : QUIET;
      check("cyc_CSRWr", 32'(CSRWr), 32'(x.wr));
      check("cyc_redirect_valid", 32'(redirect_valid), 32'(x.rv));
      check("cyc_illegal_wr", 32'(illegal_wr), 32'(x.ill));
      check("cyc_in_ready", 32'(in_ready), 32'(!(edge_n <= busy_until)));
      if (x.wr) begin
        check("cyc_csr_rd", 32'(WBU_csr_rd), 32'(x.rd));
        check("cyc_csr_busW", csr_busW, x.data);
      end
      if (x.rv) check("cyc_redirect_pc", redirect_pc, x.rpc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check({name, "_ready_timeout"}, 32'(in_ready), 32'h1);
  endtask

  // Offer one op, wait for its accept edge, return at the falling edge after it.
  task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [31:0] wd,
                       input logic [31:0] pc, input logic [31:0] ms,
                       input logic [31:0] mt, input logic [31:0] me);
    @(negedge clk);
    in_op = op; in_csr_rd = rd; in_wdata = wd; in_pc = pc;
    mstatus_cur = ms; mtvec_cur = mt; mepc_cur = me;
    in_valid = 1'b1;
    wait_ready("issue");
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    // Scramble live CSR values to prove the snapshot is what gets used.
    mstatus_cur = 32'h5555_5555; mtvec_cur = 32'h5555_5555; mepc_cur = 32'h5555_5555;
    in_pc = 32'h5555_5555; in_wdata = 32'h5555_5555;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int n;
    repeat (3) @(negedge clk);
    check("rst_CSRWr", 32'(CSRWr), 32'h0);
    check("rst_redirect_valid", 32'(redirect_valid), 32'h0);
    check("rst_illegal_wr", 32'(illegal_wr), 32'h0);
    check("rst_csr_busW", csr_busW, 32'h0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'h1);

    // WRITE mtvec
    issue(2'd1, 3'd1, 32'h8000_0100, 32'h0, 32'h0, 32'h0, 32'h0);
    check("wr_CSRWr", 32'(CSRWr), 32'h1);
    check("wr_rd", 32'(WBU_csr_rd), 32'h1);
    check("wr_data", csr_busW, 32'h8000_0100);
    check("wr_busy", 32'(in_ready), 32'h0);
    @(negedge clk);
    check("wr_ready_again", 32'(in_ready), 32'h1);

    // ECALL
    issue(2'd2, 3'd0, 32'h0, 32'h8000_0040, 32'h0000_1808, 32'h8000_0101, 32'h0);
    check("ecall_mepc", csr_busW, 32'h8000_0040);
    repeat (2) @(negedge clk);
    check("ecall_mstatus", csr_busW, 32'h0000_1880);
    @(negedge clk);
    check("ecall_redirect", redirect_pc, 32'h8000_0100);
    check("ecall_redirect_v", 32'(redirect_valid), 32'h1);

    // MRET
    issue(2'd3, 3'd0, 32'h0, 32'h0, 32'h0000_1880, 32'h0, 32'h8000_0044);
    check("mret_mstatus", csr_busW, 32'h0000_1888);
    @(negedge clk);
    check("mret_redirect", redirect_pc, 32'h8000_0044);

    // Read-only and out-of-range targets
    issue(2'd1, 3'd4, 32'h0000_DEAD, 32'h0, 32'h0, 32'h0, 32'h0);
    check("ro_no_write", 32'(CSRWr), 32'h0);
    check("ro_illegal", 32'(illegal_wr), 32'h1);
    issue(2'd1, 3'd6, 32'h0000_BEEF, 32'h0, 32'h0, 32'h0, 32'h0);
    check("idx6_no_write", 32'(CSRWr), 32'h0);
    check("idx6_no_illegal", 32'(illegal_wr), 32'h0);

    // More patterns, checked by the model
    issue(2'd1, 3'd5, 32'h1111_2222, 32'h0, 32'h0, 32'h0, 32'h0);
    issue(2'd1, 3'd7, 32'h3333_4444, 32'h0, 32'h0, 32'h0, 32'h0);
    issue(2'd1, 3'd0, 32'hA5A5_0F0F, 32'h0, 32'h0, 32'h0, 32'h0);
    issue(2'd1, 3'd3, 32'h0000_0007, 32'h0, 32'h0, 32'h0, 32'h0);
    issue(2'd0, 3'd2, 32'h9999_9999, 32'h0, 32'h0, 32'h0, 32'h0);
    issue(2'd2, 3'd0, 32'h0, 32'h8000_1234, 32'hFFFF_E777, 32'hFFFF_FFFF, 32'h0);
    issue(2'd3, 3'd0, 32'h0, 32'h0, 32'h0000_0008, 32'h0, 32'h1234_5678);
    issue(2'd3, 3'd0, 32'h0, 32'h0, 32'hAAAA_AAAA, 32'h0, 32'h8000_0000);
    issue(2'd2, 3'd0, 32'h0, 32'h0000_0004, 32'h0000_0000, 32'h0000_0002, 32'h0);

    // ECALL with in_valid held, followed by a queued WRITE
    @(negedge clk);
    in_op = 2'd2; in_pc = 32'h8000_0200; mstatus_cur = 32'h0000_0008;
    mtvec_cur = 32'h8000_0300; mepc_cur = 32'h0; in_valid = 1'b1;
    wait_ready("held");
    @(posedge clk);
    @(negedge clk);
    e = edge_n;
    in_op = 2'd1; in_csr_rd = 3'd2; in_wdata = 32'h0000_1234;
    n = 0;
    while (!(CSRWr && csr_busW == 32'h0000_1234) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("held_write_edge", 32'(edge_n - e), 32'd5);
    in_valid = 1'b0;
    @(negedge clk);

    // Reset during E_CAUSE aborts the sequence
    issue(2'd2, 3'd0, 32'h0, 32'h8000_0080, 32'h0000_1808, 32'h8000_0400, 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_CSRWr", 32'(CSRWr), 32'h0);
    check("abort_rd", 32'(WBU_csr_rd), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'h1);
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_23060136_wbu_csr_writer.md
Name: ysyx_23060136_wbu_csr_writer

Overview:
Write-side sequencer for the CSR file. It accepts one committed CSR-affecting instruction at a time from WBU: plain CSR write, ECALL, or MRET. It serializes the required updates onto the CSR file's single write port (CSRWr / WBU_csr_rd / csr_busW). For ECALL and MRET it then issues a one-cycle PC redirect to mtvec or mepc.

Parameters:
BITS_W, 32, CSR data width.
CSR_W, 3, CSR index width (indices mstatus=0, mtvec=1, mepc=2, mcause=3, mvendorid=4, marchid=5).

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-low.
in_valid  in  1  WBU offers an op.
in_ready  out  1  block can accept (high only in IDLE).
in_op  in  2  0=NONE, 1=WRITE, 2=ECALL, 3=MRET.
in_csr_rd  in  CSR_W  target index for WRITE.
in_wdata  in  BITS_W  data for WRITE.
in_pc  in  BITS_W  PC of the instruction (becomes mepc on ECALL).
mstatus_cur  in  BITS_W  live mstatus from CSR file.
mtvec_cur  in  BITS_W  live mtvec.
mepc_cur  in  BITS_W  live mepc.
CSRWr  out  1  write enable to CSR file.
WBU_csr_rd  out  CSR_W  write index.
csr_busW  out  BITS_W  write data.
redirect_valid  out  1  one-cycle PC redirect pulse.
redirect_pc  out  BITS_W  redirect target.
illegal_wr  out  1  one-cycle pulse: WRITE to a read-only index was dropped.

Behaviour:
- Reset (rst=0, async): state=IDLE. CSRWr, redirect_valid and illegal_wr = 0. WBU_csr_rd, csr_busW and redirect_pc = 0. in_ready=1 once rst deasserts. Reset mid-sequence aborts it immediately; no further writes or redirect are issued.
- All outputs except in_ready are registered. in_ready = (state==IDLE).
- Accept = in_valid & in_ready at edge t. On accept, latch op, rd, wdata and pc, and snapshot mstatus_cur, mtvec_cur and mepc_cur.
- States: IDLE, WR, E_EPC, E_CAUSE, E_STAT, M_STAT, REDIR.
- IDLE -> WR on NONE or WRITE. IDLE -> E_EPC on ECALL. IDLE -> M_STAT on MRET.
- WR, one cycle (t+1):
  - WRITE to index 0..3: CSRWr=1, WBU_csr_rd=rd, csr_busW=wdata.
  - WRITE to index 4/5 or >=6: CSRWr=0; illegal_wr=1 for 4/5 only.
  - NONE: no outputs.
  - Then -> IDLE.
- ECALL:
  - E_EPC (t+1): write mepc=pc.
  - E_CAUSE (t+2): write mcause=0xB.
  - E_STAT (t+3): write mstatus = snap with MPIE(bit7)=snap.MIE(bit3), MIE=0, MPP(12:11)=2'b11.
  - REDIR (t+4): redirect_valid=1, redirect_pc = mtvec snapshot with bits[1:0] cleared.
  - -> IDLE; in_ready=1 at t+5.
- MRET:
  - M_STAT (t+1): write mstatus = snap with MIE=snap.MPIE, MPIE=1, MPP=2'b11.
  - REDIR (t+2): redirect_pc = mepc snapshot.
  - -> IDLE.
- CSRWr is high for exactly one cycle per write. Writes are never back-to-back from different ops, because the block is never in IDLE while writing.
- in_valid while busy is ignored; WBU must hold it until in_ready.
- The mstatus snapshot is taken at accept. Later CSR writes from other sources are not seen (there are none by construction).
- Bits of mstatus other than 3, 7, 12:11 pass through unchanged.

Decomposition:
- Shared package holds:
  - CSR index constants (mstatus..marchid).
  - op enum (NONE/WRITE/ECALL/MRET).
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11).
  - MCAUSE_ECALL_M=0xB.
  - state enum.
- One natural sub-module: ysyx_23060136_wbu_mstatus_xform. It is combinational: snap plus is_mret in, new mstatus out. It is shared by E_STAT and M_STAT.

Test Plan:
1. Reset mid-ECALL: assert rst=0 during E_CAUSE -> CSRWr drops to 0 asynchronously. No mstatus write, no redirect. in_ready=1 after release.
2. WRITE mtvec=0x80000100 accepted at t -> t+1: CSRWr=1, WBU_csr_rd=1, csr_busW=0x80000100. in_ready=0 at t+1 and 1 at t+2.
3. ECALL, pc=0x80000040, mstatus_cur=0x1808, mtvec_cur=0x80000101 -> writes mepc=0x80000040 at t+1, mcause=0xB at t+2, mstatus=0x1880 at t+3. redirect_valid=1 with pc=0x80000100 at t+4.
4. MRET, mstatus_cur=0x1880, mepc_cur=0x80000044 -> t+1: mstatus=0x1888. t+2: redirect 0x80000044.
5. WRITE to mvendorid (4), wdata=0xDEAD -> CSRWr stays 0 and illegal_wr=1 at t+1. WRITE to index 6 -> no write, no illegal_wr.
6. in_valid held high across an ECALL followed by a queued WRITE -> WRITE accepted only at t+5, and its CSRWr is asserted at t+6.
